axis_packet_dispatcher_fsm: RTL and testbench
=============================================

Name: axis_packet_dispatcher_fsm

Overview:
Control stage directly upstream of the dispatcher data multiplexer. It accepts an AXI-Stream packet, holds the first beat for the header parser, and waits for a forward/drop verdict. It then sequences the packet out: parsed first beat, then the untouched remainder, or drops the packet. Its `state` output drives the multiplexer select, together with m_axis valid/keep/last/dest.

Parameters:
- AXIS_DATA_WIDTH, 64, stream data width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_DEST_WIDTH, 9, routing destination width.
- STATE_WIDTH, 3, width of the state output.
- IDLE / PARSE_DATA / CONTROL / SEND_ANALYSED_DATA / SEND_REMAIN / DROP, 0/1/2/3/4/5, state encodings.
- PARSE_TIMEOUT, 255, maximum PARSE_DATA cycles before a forced drop (must be ≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  AXIS_DATA_WIDTH  ingress data.
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  ingress keep.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tlast  in  1  ingress last.
- s_axis_tready  out  1  ingress ready.
- hdr_tdata  out  AXIS_DATA_WIDTH  registered first beat, to the parser.
- parse_start  out  1  one-cycle pulse requesting a parse.
- parse_done  in  1  parser verdict valid.
- parse_drop  in  1  verdict: 1 = drop (sampled with parse_done).
- parse_tdest  in  AXIS_DEST_WIDTH  verdict destination (sampled with parse_done).
- state  out  STATE_WIDTH  current state, to the multiplexer select.
- m_axis_tkeep  out  AXIS_KEEP_WIDTH  egress keep.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tlast  out  1  egress last.
- m_axis_tdest  out  AXIS_DEST_WIDTH  egress destination, held for the whole packet.
- m_axis_tready  in  1  egress ready.

Behaviour:
Reset:
- Asynchronous on rst_n low, for the full FSM and all registers.
- Resulting values: state=IDLE; hdr_tdata, hdr_keep, hdr_last = 0; m_axis_tdest=0; parse_start=0; timeout counter=0.
- Reset mid-packet abandons the packet. The remaining beats are treated as a new packet after reset; no recovery.

Per-state rules:
- IDLE: s_axis_tready=1. On s_axis_tvalid, register tdata/tkeep/tlast into hdr_*, then go to PARSE_DATA.
- PARSE_DATA:
  - s_axis_tready=0.
  - parse_start=1 on the first PARSE_DATA cycle only (registered pulse).
  - The timeout counter increments each cycle.
  - On parse_done: latch parse_drop and parse_tdest, go to CONTROL.
  - If the counter reaches PARSE_TIMEOUT without parse_done: force drop=1, go to CONTROL.
  - parse_done in the same cycle as the timeout wins: the verdict is used.
- CONTROL: single cycle. Clear the counter. Go to DROP if drop=1, else SEND_ANALYSED_DATA.
- SEND_ANALYSED_DATA:
  - m_axis_tvalid=1, m_axis_tkeep=hdr_keep, m_axis_tlast=hdr_last. The data beat is supplied by the parser through the multiplexer.
  - On m_axis_tready: go to IDLE if hdr_last, else SEND_REMAIN.
- SEND_REMAIN:
  - Combinational pass-through: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, tkeep/tlast from s_axis.
  - On a handshake with s_axis_tlast=1: go to IDLE.
- DROP:
  - If hdr_last: go to IDLE next cycle with s_axis_tready=0.
  - Otherwise s_axis_tready=1, discard beats until a tlast beat is accepted, then go to IDLE.
- Outside SEND_ANALYSED_DATA and SEND_REMAIN: m_axis_tvalid=0 and m_axis_tkeep=0.

Stream rules:
- m_axis_tdest is valid from CONTROL until the packet completes.
- Single-beat packets never enter SEND_REMAIN.
- AXIS stability: once m_axis_tvalid is asserted, it holds until the handshake.

Latency:
- Minimum first-beat latency, ingress to egress valid, is 3 cycles + parser latency (IDLE→PARSE_DATA→CONTROL→SEND_ANALYSED_DATA).
- One idle bubble occurs between packets (IDLE accept cycle).

Optional Feature:
DISPATCHER_STATS_EN
- Defined: adds outputs stat_pkt_fwd [31:0], stat_pkt_drop [31:0], stat_pkt_timeout [31:0].
  - stat_pkt_fwd increments on the CONTROL→SEND_ANALYSED_DATA transition.
  - stat_pkt_drop increments on CONTROL→DROP.
  - stat_pkt_timeout increments on a timeout-forced drop; a timeout drop also counts in stat_pkt_drop.
  - All counters wrap at 2^32, reset to 0, and are saturation-free.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- 3-beat packet, parse_done with drop=0, tdest=5 two cycles after parse_start, m_axis_tready=1 → state sequence 0,1,1,1,2,3,4,4; 3 egress beats; tdest=5; last only on beat 3; return to IDLE.
- Single-beat packet (tlast on first beat), verdict forward → SEND_ANALYSED_DATA→IDLE; SEND_REMAIN never entered; exactly one egress beat with tlast=1.
- 4-beat packet, parse_drop=1 → m_axis_tvalid stays 0; 3 remaining beats consumed with s_axis_tready=1; IDLE after tlast; stat_pkt_drop=1 (if enabled).
- Parser silent, PARSE_TIMEOUT=8 → exactly 8 PARSE_DATA cycles, then CONTROL→DROP; packet consumed; stat_pkt_timeout=1.
- Egress backpressure: m_axis_tready toggles 1,0,0,1 during SEND_REMAIN → s_axis_tready mirrors m_axis_tready; no beat lost or duplicated; m_axis_tvalid held while stalled.
- rst_n low for 1 cycle mid-SEND_REMAIN → all outputs at reset values immediately (asynchronous); state=IDLE; next ingress beat treated as a header.

Source files
------------

// File: rtl/axis_packet_dispatcher_fsm.sv
// axis_packet_dispatcher_fsm
//
// Purpose:
//   Control stage in front of the dispatcher data multiplexer. It accepts an
//   AXI-Stream packet and captures its first beat for the header parser. It
//   then waits for a forward/drop verdict, or for a parse timeout. On forward
//   it emits the analysed first beat and passes the remainder of the packet
//   straight through. On drop it swallows the rest of the packet. The
//   current state is exported so the downstream multiplexer can select
//   between parser data and the raw ingress stream.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axis_*          ingress stream (tdata/tkeep/tvalid/tlast in, tready out)
//   hdr_tdata         registered first beat handed to the parser
//   parse_start       one-cycle request pulse to the parser
//   parse_done        parser verdict valid
//   parse_drop        verdict: 1 = drop
//   parse_tdest       verdict destination
//   state             current FSM state, multiplexer select
//   m_axis_*          egress control (tkeep/tvalid/tlast/tdest out, tready in)
//
// Optional feature (macro DISPATCHER_STATS_EN):
//   Adds the 32-bit wrapping counters stat_pkt_fwd, stat_pkt_drop and
//   stat_pkt_timeout. Without the macro these ports do not exist.

module axis_packet_dispatcher_fsm #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 9,
    parameter int STATE_WIDTH     = 3,
    parameter logic [STATE_WIDTH-1:0] IDLE               = 0,
    parameter logic [STATE_WIDTH-1:0] PARSE_DATA         = 1,
    parameter logic [STATE_WIDTH-1:0] CONTROL            = 2,
    parameter logic [STATE_WIDTH-1:0] SEND_ANALYSED_DATA = 3,
    parameter logic [STATE_WIDTH-1:0] SEND_REMAIN        = 4,
    parameter logic [STATE_WIDTH-1:0] DROP               = 5,
    parameter int PARSE_TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] hdr_tdata,
    output logic                       parse_start,
    input  logic                       parse_done,
    input  logic                       parse_drop,
    input  logic [AXIS_DEST_WIDTH-1:0] parse_tdest,
    output logic [STATE_WIDTH-1:0]     state,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                       m_axis_tready
`ifdef DISPATCHER_STATS_EN
    ,
    output logic [31:0]                stat_pkt_fwd,
    output logic [31:0]                stat_pkt_drop,
    output logic [31:0]                stat_pkt_timeout
`endif
);

    // Counter is wide enough to hold PARSE_TIMEOUT itself, since it still
    // increments on the final PARSE_DATA cycle before CONTROL clears it.
    localparam int CNT_W = (PARSE_TIMEOUT < 2) ? 1 : $clog2(PARSE_TIMEOUT + 1);

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE               = IDLE,
        ST_PARSE_DATA         = PARSE_DATA,
        ST_CONTROL            = CONTROL,
        ST_SEND_ANALYSED_DATA = SEND_ANALYSED_DATA,
        ST_SEND_REMAIN        = SEND_REMAIN,
        ST_DROP               = DROP
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [AXIS_KEEP_WIDTH-1:0] hdr_keep;
    logic                       hdr_last;
    logic                       drop_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       timeout;
    logic                       accept_hdr;

    // The counter reads PARSE_TIMEOUT-1 on the PARSE_TIMEOUT-th cycle, so
    // exactly PARSE_TIMEOUT PARSE_DATA cycles elapse before a forced drop.
    assign timeout    = (cnt_q == CNT_W'(PARSE_TIMEOUT - 1));
    assign accept_hdr = (state_q == ST_IDLE) && s_axis_tvalid;
    assign state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Header capture, verdict latching and parse timeout counter.
    // parse_start is registered off the IDLE accept so it lands on the
    // first PARSE_DATA cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_tdata    <= '0;
            hdr_keep     <= '0;
            hdr_last     <= 1'b0;
            drop_q       <= 1'b0;
            m_axis_tdest <= '0;
            parse_start  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            parse_start <= accept_hdr;
            if (accept_hdr) begin
                hdr_tdata <= s_axis_tdata;
                hdr_keep  <= s_axis_tkeep;
                hdr_last  <= s_axis_tlast;
            end
            if (state_q == ST_PARSE_DATA) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (parse_done) begin
                    drop_q       <= parse_drop;
                    m_axis_tdest <= parse_tdest;
                end else if (timeout) begin
                    drop_q <= 1'b1;
                end
            end else if (state_q == ST_CONTROL) begin
                cnt_q <= '0;
            end
        end
    end

    // Next-state and stream handshake logic. SEND_REMAIN is a pure
    // combinational pass-through between ingress and egress.
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    state_d = ST_PARSE_DATA;
                end
            end
            ST_PARSE_DATA: begin
                if (parse_done || timeout) begin
                    state_d = ST_CONTROL;
                end
            end
            ST_CONTROL: begin
                state_d = drop_q ? ST_DROP : ST_SEND_ANALYSED_DATA;
            end
            ST_SEND_ANALYSED_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tkeep  = hdr_keep;
                m_axis_tlast  = hdr_last;
                if (m_axis_tready) begin
                    state_d = hdr_last ? ST_IDLE : ST_SEND_REMAIN;
                end
            end
            ST_SEND_REMAIN: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // A single-beat packet has nothing left to discard.
                if (hdr_last) begin
                    state_d = ST_IDLE;
                end else begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DISPATCHER_STATS_EN
    // Packet statistics. A timeout also counts as a drop when CONTROL
    // routes the packet to DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_fwd     <= '0;
            stat_pkt_drop    <= '0;
            stat_pkt_timeout <= '0;
        end else begin
            if (state_q == ST_CONTROL && !drop_q) begin
                stat_pkt_fwd <= stat_pkt_fwd + 32'd1;
            end
            if (state_q == ST_CONTROL && drop_q) begin
                stat_pkt_drop <= stat_pkt_drop + 32'd1;
            end
            if (state_q == ST_PARSE_DATA && timeout && !parse_done) begin
                stat_pkt_timeout <= stat_pkt_timeout + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_packet_dispatcher_fsm.sv
// tb_axis_packet_dispatcher_fsm
//
// Purpose:
//   Self-checking bench for axis_packet_dispatcher_fsm. Every forwarded
//   packet is queued as its list of expected egress beats (keep, last, dest).
//   A per-cycle compare process pops that queue on each egress handshake.
//   It also enforces the stream rules: no valid without a pending beat,
//   valid held while stalled, and the SEND_REMAIN pass-through.
//   Directed tests pin literal state traces and beat counts.
//
// Ports: none (top-level bench). Honours DISPATCHER_STATS_EN if defined.

module tb_axis_packet_dispatcher_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [63:0] hdr_tdata;
    logic        parse_start;
    logic        parse_done = 1'b0;
    logic        parse_drop = 1'b0;
    logic [8:0]  parse_tdest = '0;
    logic [2:0]  state;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [8:0]  m_axis_tdest;
    logic        m_axis_tready = 1'b1;
`ifdef DISPATCHER_STATS_EN
    logic [31:0] stat_pkt_fwd;
    logic [31:0] stat_pkt_drop;
    logic [31:0] stat_pkt_timeout;
`endif

    always #5 clk = ~clk;

    axis_packet_dispatcher_fsm #(
        .PARSE_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .hdr_tdata(hdr_tdata),
        .parse_start(parse_start),
        .parse_done(parse_done),
        .parse_drop(parse_drop),
        .parse_tdest(parse_tdest),
        .state(state),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tdest(m_axis_tdest),
        .m_axis_tready(m_axis_tready)
`ifdef DISPATCHER_STATS_EN
        ,
        .stat_pkt_fwd(stat_pkt_fwd),
        .stat_pkt_drop(stat_pkt_drop),
        .stat_pkt_timeout(stat_pkt_timeout)
`endif
    );

    typedef struct packed {
        logic [7:0] keep;
        logic       last;
        logic [8:0] dest;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      popped;
    logic [2:0] trace[$];
    int         total = 0;
    int         bad = 0;
    int         cnt_parse = 0;
    int         cnt_sr = 0;
    int         cnt_start = 0;
    int         cnt_in = 0;
    int         cnt_out = 0;
    logic       prev_stall = 1'b0;
    logic       bp_pat[4];

    // Central comparison: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] beatData(input logic [7:0] kbase, input int i);
        return {32'hCAFE_0000, 16'(kbase), 16'(i)};
    endfunction

    // Model of a forwarded packet: the analysed first beat carries the
    // header keep/last, the rest pass through unchanged, all with one dest.
    task automatic expectPacket(input int n, input logic [7:0] kbase,
                                input bit last_at_end, input logic [8:0] dest);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.keep = kbase + 8'(i);
            b.last = last_at_end && (i == n - 1);
            b.dest = dest;
            exp_q.push_back(b);
        end
    endtask

    task automatic clearStats();
        trace.delete();
        cnt_parse = 0;
        cnt_sr = 0;
        cnt_start = 0;
        cnt_in = 0;
        cnt_out = 0;
    endtask

    // Ingress driver: presents n beats, each held until accepted.
    task automatic applyStimulus(input int n, input logic [7:0] kbase,
                                 input bit last_at_end);
        int waited;
        bit ok;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beatData(kbase, i);
            s_axis_tkeep  = kbase + 8'(i);
            s_axis_tlast  = last_at_end && (i == n - 1);
            waited = 0;
            ok = 1'b0;
            while (!ok && waited < 200) begin
                @(negedge clk);
                if (s_axis_tready) ok = 1'b1;
                waited++;
            end
            if (!ok) checkOutput("ingress_accept_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Parser model: waits for parse_start, checks the captured header and
    // answers 'delay' cycles later, unless silent.
    task automatic parserRespond(input int delay, input bit drop,
                                 input logic [8:0] dest, input bit silent,
                                 input logic [63:0] exp_hdr);
        int waited;
        bit seen;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            if (parse_start) seen = 1'b1;
            waited++;
        end
        if (!seen) begin
            checkOutput("parse_start_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("hdr_tdata", hdr_tdata, exp_hdr);
            if (!silent) begin
                repeat (delay) begin
                    @(posedge clk);
                    #1;
                end
                if (delay == 0) begin
                    @(posedge clk);
                    #1;
                    // parse_start was seen in the first PARSE_DATA cycle;
                    // answering now would be the second, so step back is
                    // impossible. Zero delay is modelled as the first
                    // available cycle after the pulse.
                end
                parse_done  = 1'b1;
                parse_drop  = drop;
                parse_tdest = dest;
                @(posedge clk);
                #1;
                parse_done  = 1'b0;
                parse_drop  = 1'b0;
                parse_tdest = '0;
            end
        end
    endtask

    task automatic waitIdle();
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (exp_q.size() == 0 && state == 3'd0 && !s_axis_tvalid) ok = 1'b1;
            waited++;
        end
        if (!ok) checkOutput("idle_timeout", 64'd0, 64'd1);
        checkOutput("pending_beats", 64'(exp_q.size()), 64'd0);
        checkOutput("state_idle", 64'(state), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare process against the beat-queue model.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            trace.push_back(state);
            if (state == 3'd1) cnt_parse++;
            if (state == 3'd4) cnt_sr++;
            if (parse_start) cnt_start++;
            if (s_axis_tvalid && s_axis_tready) cnt_in++;
            if (exp_q.size() == 0) checkOutput("idle_egress_valid", 64'(m_axis_tvalid), 64'd0);
            if (prev_stall) checkOutput("valid_held", 64'(m_axis_tvalid), 64'd1);
            if (state == 3'd4) begin
                checkOutput("remain_tready", 64'(s_axis_tready), 64'(m_axis_tready));
                checkOutput("remain_tvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                cnt_out++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_egress", 64'd1, 64'd0);
                end else begin
                    popped = exp_q.pop_front();
                    checkOutput("egress_tkeep", 64'(m_axis_tkeep), 64'(popped.keep));
                    checkOutput("egress_tlast", 64'(m_axis_tlast), 64'(popped.last));
                    checkOutput("egress_tdest", 64'(m_axis_tdest), 64'(popped.dest));
                end
            end
            prev_stall <= m_axis_tvalid && !m_axis_tready;
        end
    end

    initial begin
        bp_pat[0] = 1'b1;
        bp_pat[1] = 1'b0;
        bp_pat[2] = 1'b0;
        bp_pat[3] = 1'b1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_parse_start", 64'(parse_start), 64'd0);
        checkOutput("rst_tdest", 64'(m_axis_tdest), 64'd0);
        checkOutput("rst_hdr", hdr_tdata, 64'd0);
        checkOutput("rst_s_tready", 64'(s_axis_tready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat forward, verdict two cycles after parse_start
        clearStats();
        expectPacket(3, 8'h10, 1'b1, 9'd5);
        fork
            applyStimulus(3, 8'h10, 1'b1);
            parserRespond(2, 1'b0, 9'd5, 1'b0, beatData(8'h10, 0));
        join
        waitIdle();
        begin
            logic [2:0] exp_tr[8];
            exp_tr = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
            if (trace.size() < 8) begin
                checkOutput("t1_trace_len", 64'(trace.size()), 64'd8);
            end else begin
                for (int i = 0; i < 8; i++)
                    checkOutput($sformatf("t1_trace_%0d", i), 64'(trace[i]), 64'(exp_tr[i]));
            end
        end
        checkOutput("t1_beats_out", 64'(cnt_out), 64'd3);
        checkOutput("t1_start_pulses", 64'(cnt_start), 64'd1);

        // Single-beat forward
        clearStats();
        expectPacket(1, 8'h20, 1'b1, 9'd17);
        fork
            applyStimulus(1, 8'h20, 1'b1);
            parserRespond(0, 1'b0, 9'd17, 1'b0, beatData(8'h20, 0));
        join
        waitIdle();
        checkOutput("t2_remain_cycles", 64'(cnt_sr), 64'd0);
        checkOutput("t2_beats_out", 64'(cnt_out), 64'd1);

        // 4-beat drop
        clearStats();
        fork
            applyStimulus(4, 8'h50, 1'b1);
            parserRespond(1, 1'b1, 9'd9, 1'b0, beatData(8'h50, 0));
        join
        waitIdle();
        checkOutput("t3_beats_in", 64'(cnt_in), 64'd4);
        checkOutput("t3_beats_out", 64'(cnt_out), 64'd0);
`ifdef DISPATCHER_STATS_EN
        checkOutput("t3_stat_drop", 64'(stat_pkt_drop), 64'd1);
        checkOutput("t3_stat_fwd", 64'(stat_pkt_fwd), 64'd2);
`endif

        // Parser silent: timeout after exactly 8 PARSE_DATA cycles
        clearStats();
        fork
            applyStimulus(4, 8'h60, 1'b1);
            parserRespond(0, 1'b0, 9'd0, 1'b1, beatData(8'h60, 0));
        join
        waitIdle();
        checkOutput("t4_parse_cycles", 64'(cnt_parse), 64'd8);
        checkOutput("t4_beats_in", 64'(cnt_in), 64'd4);
        if (trace.size() < 11) begin
            checkOutput("t4_trace_len", 64'(trace.size()), 64'd11);
        end else begin
            checkOutput("t4_trace_control", 64'(trace[9]), 64'd2);
            checkOutput("t4_trace_drop", 64'(trace[10]), 64'd5);
        end
`ifdef DISPATCHER_STATS_EN
        checkOutput("t4_stat_timeout", 64'(stat_pkt_timeout), 64'd1);
        checkOutput("t4_stat_drop", 64'(stat_pkt_drop), 64'd2);
`endif

        // Egress backpressure 1,0,0,1 during SEND_REMAIN
        clearStats();
        expectPacket(4, 8'h30, 1'b1, 9'h1AB);
        fork
            applyStimulus(4, 8'h30, 1'b1);
            parserRespond(1, 1'b0, 9'h1AB, 1'b0, beatData(8'h30, 0));
            begin
                int idx;
                int guard;
                idx = 0;
                guard = 0;
                while (idx < 4 && guard < 200) begin
                    @(posedge clk);
                    #1;
                    guard++;
                    if (state == 3'd4) begin
                        m_axis_tready = bp_pat[idx];
                        idx++;
                    end
                end
                m_axis_tready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("t5_beats_out", 64'(cnt_out), 64'd4);
        checkOutput("t5_remain_cycles", 64'(cnt_sr), 64'd5);

        // Reset in the middle of SEND_REMAIN
        clearStats();
        expectPacket(2, 8'h40, 1'b0, 9'd3);
        fork
            applyStimulus(2, 8'h40, 1'b0);
            parserRespond(0, 1'b0, 9'd3, 1'b0, beatData(8'h40, 0));
        join
        checkOutput("t6_pre_state", 64'(state), 64'd4);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("t6_rst_state", 64'(state), 64'd0);
        checkOutput("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t6_rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        checkOutput("t6_rst_tdest", 64'(m_axis_tdest), 64'd0);
        checkOutput("t6_rst_hdr", hdr_tdata, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clearStats();
        expectPacket(2, 8'h42, 1'b1, 9'd7);
        fork
            applyStimulus(2, 8'h42, 1'b1);
            parserRespond(1, 1'b0, 9'd7, 1'b0, beatData(8'h42, 0));
        join
        waitIdle();
        checkOutput("t6_beats_out", 64'(cnt_out), 64'd2);
        checkOutput("t6_start_pulses", 64'(cnt_start), 64'd1);
`ifdef DISPATCHER_STATS_EN
        checkOutput("t6_stat_fwd", 64'(stat_pkt_fwd), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
